// File: rtl/uart_rx_controller.sv
// UART receive controller: 16x oversample tick generator, first-word-fall-through
// byte FIFO with ready/valid read side, sticky overrun flag and idle timeout.
module uart_rx_controller #(
    parameter int unsigned DataBits     = 8,
    parameter int unsigned FifoDepth    = 4,
    parameter int unsigned DivWidth     = 11,
    parameter int unsigned TimeoutTicks = 640
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic [DivWidth-1:0]          divisor,
    input  logic                         flush,
    input  logic                         overrun_clr,
    input  logic                         rx_done_tick,
    input  logic [DataBits-1:0]          rx_dout,
    output logic                         s_tick,
    output logic                         rd_valid,
    output logic [DataBits-1:0]          rd_data,
    input  logic                         rd_ready,
    output logic [$clog2(FifoDepth):0]   fifo_count,
    output logic                         overrun,
    output logic                         idle_timeout
);

    localparam int unsigned PtrW = $clog2(FifoDepth);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned ToW  = $clog2(TimeoutTicks + 1);
    localparam logic [CntW-1:0] CountFull = CntW'(FifoDepth);
    localparam logic [ToW-1:0]  ToMax     = ToW'(TimeoutTicks);

    // Baud generator state
    logic [DivWidth-1:0] cnt_q, cnt_d;
    logic                s_tick_q, s_tick_d;

    // FIFO state
    logic [DataBits-1:0] mem_q [FifoDepth];
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]     count_q, count_d;
    logic                overrun_q, overrun_d;

    // Idle timeout state
    logic [ToW-1:0]      to_cnt_q, to_cnt_d;

    logic full;
    logic pop;
    logic wr_en;
    logic drop;

    assign full  = (count_q == CountFull);
    assign pop   = rd_valid & rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign wr_en = ~flush & rx_done_tick & (~full | pop);
    assign drop  = ~flush & rx_done_tick & full & ~pop;

    // Baud generator next state; >= lets a lowered divisor wrap immediately.
    always_comb begin
        cnt_d    = '0;
        s_tick_d = 1'b0;
        if (enable) begin
            if (cnt_q >= divisor) begin
                s_tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + DivWidth'(1);
            end
        end
    end

    // FIFO pointer/count next state; flush overrides push and pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (wr_en && !pop) begin
                count_d = count_q + CntW'(1);
            end else if (pop && !wr_en) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    // Sticky overrun; a drop in the same cycle as a clear wins.
    always_comb begin
        overrun_d = overrun_q;
        if (overrun_clr) begin
            overrun_d = 1'b0;
        end
        if (drop) begin
            overrun_d = 1'b1;
        end
    end

    // Idle timeout counter: restarts on any FIFO activity, saturates at the limit.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (flush || rx_done_tick || pop || (count_q == '0)) begin
            to_cnt_d = '0;
        end else if (s_tick_q && (to_cnt_q != ToMax)) begin
            to_cnt_d = to_cnt_q + ToW'(1);
        end
    end

    // Control and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            s_tick_q  <= 1'b0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            to_cnt_q  <= '0;
        end else begin
            cnt_q     <= cnt_d;
            s_tick_q  <= s_tick_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    // FIFO storage, cleared on reset so rd_data reads 0 out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(FifoDepth); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_ptr_q] <= rx_dout;
        end
    end

    assign s_tick       = s_tick_q;
    assign rd_valid     = (count_q != '0);
    assign rd_data      = mem_q[rd_ptr_q];
    assign fifo_count   = count_q;
    assign overrun      = overrun_q;
    assign idle_timeout = (to_cnt_q == ToMax) && (count_q != '0);

endmodule

// File: tb/tb_uart_rx_controller.sv
// Self-checking bench for uart_rx_controller: scoreboard queue of expected bytes,
// checked on every consumer pop and every cycle for count/valid/head/overrun.
module tb_uart_rx_controller;

    localparam int unsigned DataBits     = 8;
    localparam int unsigned FifoDepth    = 4;
    localparam int unsigned DivWidth     = 11;
    localparam int unsigned TimeoutTicks = 640;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                enable = 1'b0;
    logic [DivWidth-1:0] divisor = '0;
    logic                flush = 1'b0;
    logic                overrun_clr = 1'b0;
    logic                rx_done_tick = 1'b0;
    logic [DataBits-1:0] rx_dout = '0;
    logic                s_tick;
    logic                rd_valid;
    logic [DataBits-1:0] rd_data;
    logic                rd_ready = 1'b0;
    logic [2:0]          fifo_count;
    logic                overrun;
    logic                idle_timeout;

    uart_rx_controller #(
        .DataBits    (DataBits),
        .FifoDepth   (FifoDepth),
        .DivWidth    (DivWidth),
        .TimeoutTicks(TimeoutTicks)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .divisor     (divisor),
        .flush       (flush),
        .overrun_clr (overrun_clr),
        .rx_done_tick(rx_done_tick),
        .rx_dout     (rx_dout),
        .s_tick      (s_tick),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_ready    (rd_ready),
        .fifo_count  (fifo_count),
        .overrun     (overrun),
        .idle_timeout(idle_timeout)
    );

    always #5 clk = ~clk;

    int unsigned   n_total = 0;
    int unsigned   n_bad   = 0;
    logic [7:0]    sb[$];
    logic          model_ov = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock: update the model with this cycle's inputs, then check state.
    task automatic tick();
        logic       do_pop;
        logic       was_full;
        logic [7:0] e;
        do_pop   = rd_ready && (sb.size() != 0) && !flush;
        was_full = (sb.size() == FifoDepth);
        if (flush) begin
            sb.delete();
        end else begin
            if (do_pop) begin
                e = sb.pop_front();
                check("pop_data", {24'd0, rd_data}, {24'd0, e});
            end
            if (rx_done_tick && (!was_full || do_pop)) begin
                sb.push_back(rx_dout);
            end
        end
        if (overrun_clr) model_ov = 1'b0;
        if (!flush && rx_done_tick && was_full && !do_pop) model_ov = 1'b1;
        @(posedge clk);
        #1;
        rx_done_tick = 1'b0;
        flush        = 1'b0;
        overrun_clr  = 1'b0;
        check("count", {29'd0, fifo_count}, sb.size());
        check("valid", {31'd0, rd_valid}, {31'd0, sb.size() != 0});
        if (sb.size() != 0) check("head", {24'd0, rd_data}, {24'd0, sb[0]});
        check("overrun", {31'd0, overrun}, {31'd0, model_ov});
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_done_tick = 1'b1;
        rx_dout      = b;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_tick", {31'd0, s_tick}, 0);
        check("rst_valid", {31'd0, rd_valid}, 0);
        check("rst_data", {24'd0, rd_data}, 0);
        check("rst_count", {29'd0, fifo_count}, 0);
        check("rst_overrun", {31'd0, overrun}, 0);
        check("rst_timeout", {31'd0, idle_timeout}, 0);
        reset_n = 1'b1;

        // Baud generation: divisor 3 -> every 4th cycle
        enable  = 1'b1;
        divisor = 11'd3;
        for (int c = 1; c <= 12; c++) begin
            tick();
            check("tick_div3", {31'd0, s_tick}, {31'd0, (c % 4) == 0});
        end
        divisor = 11'd0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("tick_div0", {31'd0, s_tick}, 1);
        end
        enable = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("tick_off", {31'd0, s_tick}, 0);
        end

        // Ordered buffering
        rd_ready = 1'b0;
        push_byte(8'hA5);
        push_byte(8'h3C);
        push_byte(8'hFF);
        check("ord_count", {29'd0, fifo_count}, 3);
        check("ord_head", {24'd0, rd_data}, 32'hA5);
        rd_ready = 1'b1;
        repeat (3) tick();
        check("ord_empty", {31'd0, rd_valid}, 0);
        rd_ready = 1'b0;

        // Full FIFO: drop, push-with-pop, clear
        for (int i = 1; i <= 4; i++) push_byte(8'(i));
        push_byte(8'h11);
        check("full_overrun", {31'd0, overrun}, 1);
        check("full_count", {29'd0, fifo_count}, 4);
        rd_ready = 1'b1;
        push_byte(8'h22);
        rd_ready = 1'b0;
        check("full_pp_count", {29'd0, fifo_count}, 4);
        overrun_clr = 1'b1;
        tick();
        check("ov_clr", {31'd0, overrun}, 0);
        rd_ready = 1'b1;
        repeat (4) tick();
        rd_ready = 1'b0;

        // Wrap-around streaming
        rd_ready = 1'b1;
        for (int i = 0; i < 10; i++) push_byte(8'(i));
        repeat (2) tick();
        rd_ready = 1'b0;

        // Idle timeout with divisor 0
        divisor = 11'd0;
        enable  = 1'b1;
        push_byte(8'h5A);
        for (int i = 1; i <= int'(TimeoutTicks); i++) begin
            tick();
            check("timeout", {31'd0, idle_timeout}, {31'd0, i == int'(TimeoutTicks)});
        end
        tick();
        check("timeout_hold", {31'd0, idle_timeout}, 1);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("timeout_clr", {31'd0, idle_timeout}, 0);

        // Flush coincident with push keeps overrun
        for (int i = 0; i < 5; i++) push_byte(8'h40 + 8'(i));
        check("fl_pre_ov", {31'd0, overrun}, 1);
        flush = 1'b1;
        push_byte(8'h77);
        check("flush_count", {29'd0, fifo_count}, 0);
        check("flush_ov", {31'd0, overrun}, 1);

        // Asynchronous reset with 3 entries
        push_byte(8'h10);
        push_byte(8'h20);
        push_byte(8'h30);
        reset_n = 1'b0;
        #1;
        check("arst_count", {29'd0, fifo_count}, 0);
        check("arst_valid", {31'd0, rd_valid}, 0);
        check("arst_data", {24'd0, rd_data}, 0);
        check("arst_s_tick", {31'd0, s_tick}, 0);
        check("arst_overrun", {31'd0, overrun}, 0);
        check("arst_timeout", {31'd0, idle_timeout}, 0);
        sb.delete();
        model_ov = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        push_byte(8'hC3);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
